// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared encodings and constants for the multdiv issue controller
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          TIMEOUT_DEFAULT = 40;
  localparam logic [4:0]  EXC_REG         = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE   = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE    = 32'd5;

  function automatic logic [31:0] exc_code(input logic is_mult);
    return is_mult ? MULT_EXC_CODE : DIV_EXC_CODE;
  endfunction

endpackage

// File: rtl/multdiv_timer.sv
// rtl/multdiv_timer.sv - clearable RUN-cycle counter with terminal-count flag
module multdiv_timer #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [5:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 6'd0;
    end else if (clear) begin
      count <= 6'd0;
    end else if (enable) begin
      count <= count + 6'd1;
    end
  end

  // count holds the number of RUN cycles already completed, so this fires
  // during the TIMEOUT-th RUN cycle
  assign expired = enable && (count == 6'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue.sv
// rtl/multdiv_issue.sv - issue/writeback controller in front of the iterative multiplier and divider
module multdiv_issue
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_is_mult,
  input  logic        in_is_div,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  output logic        stall,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] unit_result,
  input  logic        unit_exception,
  input  logic        unit_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_result,
  input  logic        wb_ack
);

  state_t     state;
  logic [4:0] rd_q;
  logic       is_mult;
  logic       timer_expired;

  multdiv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == ST_START),
    .enable  (state == ST_RUN),
    .expired (timer_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      stall     <= 1'b0;
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      wb_rd     <= 5'd0;
      wb_result <= 32'd0;
      rd_q      <= 5'd0;
      is_mult   <= 1'b0;
    end else begin
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // mult takes priority when both kind flags are set
          if (in_valid && (in_is_mult || in_is_div)) begin
            op_a      <= in_a;
            op_b      <= in_b;
            rd_q      <= in_rd;
            is_mult   <= in_is_mult;
            ctrl_MULT <= in_is_mult;
            ctrl_DIV  <= !in_is_mult;
            stall     <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (unit_resultRDY && !unit_exception) begin
            wb_rd     <= rd_q;
            wb_result <= unit_result;
            wb_valid  <= 1'b1;
            state     <= ST_DONE;
          end else if (unit_resultRDY || timer_expired) begin
            wb_rd     <= EXC_REG;
            wb_result <= exc_code(is_mult);
            wb_valid  <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (wb_ack) begin
            wb_valid <= 1'b0;
            stall    <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
